debounce_event_sched: RTL

Multi-channel button front end that sequences debouncing for NCH noisy inputs with one shared sample-tick prescaler. It turns each channel's stable transitions into press/release events. A round-robin scheduler then serialises those events onto one valid/ready event port for the control FSM or CPU-facing register block. It replaces per-button free-running debouncers with a single scheduled resource and an ordered event stream.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/debounce_chan.sv | 116 +++++++++++
 rtl/debounce_event_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
//==============================================================================
// Module      : debounce_pkg
// Description : Event-type encodings and width helpers shared by the
//               multi-channel debounce / event scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package debounce_pkg;

    localparam int EVT_W = 2;

    typedef enum logic [EVT_W-1:0] {
        EVT_RELEASE = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_LONG    = 2'b10
    } evt_type_e;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
//==============================================================================
// Module      : debounce_chan
// Description : One button channel: 2-flop synchroniser, tick-driven
//               stability counter, clean level and one-clock event strobe.
//               LONG_PRESS_EN adds a saturating hold counter and long-press event.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 13
`ifdef LONG_PRESS_EN
    ,
    parameter int LONG_TICKS   = 40
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             noisy_i,
    output logic             clean_o,
    output logic             evt_o,
    output logic [EVT_W-1:0] evt_type_o
);

    localparam int CNT_W = ch_width(STABLE_TICKS + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic [EVT_W-1:0] type_q, type_d;
    logic             stable_fire;
    logic             long_fire;

    always_comb begin
        cnt_d       = cnt_q;
        clean_d     = clean_q;
        stable_fire = 1'b0;
        if (tick_i) begin
            if (sync2_q == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
                cnt_d       = '0;
                clean_d     = sync2_q;
                stable_fire = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = ch_width(LONG_TICKS + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // A release tick wins over a coincident long-press; the hold clears once clean drops.
    always_comb begin
        hold_d    = hold_q;
        long_fire = 1'b0;
        if (!clean_q) begin
            hold_d = '0;
        end else if (tick_i && !stable_fire && (hold_q != HOLD_W'(LONG_TICKS))) begin
            hold_d    = hold_q + 1'b1;
            long_fire = (hold_q == HOLD_W'(LONG_TICKS - 1));
        end
    end
`else
    assign long_fire = 1'b0;
`endif

    always_comb begin
        evt_d  = stable_fire | long_fire;
        type_d = type_q;
        if (stable_fire) begin
            type_d = sync2_q ? EVT_PRESS : EVT_RELEASE;
        end else if (long_fire) begin
            type_d = EVT_LONG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            type_q  <= EVT_RELEASE;
`ifdef LONG_PRESS_EN
            hold_q  <= '0;
`endif
        end else begin
            sync1_q <= noisy_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            type_q  <= type_d;
`ifdef LONG_PRESS_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign clean_o    = clean_q;
    assign evt_o      = evt_q;
    assign evt_type_o = type_q;

endmodule

`default_nettype wire

// File: rtl/debounce_event_sched.sv
//==============================================================================
// Module      : debounce_event_sched
// Description : NCH-channel debouncer sharing one sample-tick prescaler; events
//               are parked in one-entry slots and serialised round-robin onto a
//               valid/ready port. Optional macro LONG_PRESS_EN adds long-press.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_event_sched
    import debounce_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 13,
    parameter int LONG_TICKS   = 40
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCH-1:0]              noisy,
    output logic [NCH-1:0]              clean,
    output logic                        evt_valid,
    output logic [ch_width(NCH)-1:0]    evt_ch,
    output logic [EVT_W-1:0]            evt_type,
    input  logic                        evt_ready,
    output logic                        evt_ovf
);

    localparam int CH_W  = ch_width(NCH);
    localparam int DIV_W = ch_width(TICK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    logic [NCH-1:0]   chan_evt;
    logic [EVT_W-1:0] chan_type [NCH];

    logic [NCH-1:0]   slot_vld_q, slot_vld_d;
    logic [EVT_W-1:0] slot_type_q [NCH];
    logic [EVT_W-1:0] slot_type_d [NCH];
    logic [NCH-1:0]   drain;

    logic [CH_W-1:0]  rr_q, rr_d;
    logic [CH_W-1:0]  scan_idx;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_ch;
    logic             load_out;

    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic [EVT_W-1:0] evt_type_q, evt_type_d;
    logic             ovf_q, ovf_d;

    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS)
`ifdef LONG_PRESS_EN
            ,
            .LONG_TICKS   (LONG_TICKS)
`endif
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (tick),
            .noisy_i    (noisy[g]),
            .clean_o    (clean[g]),
            .evt_o      (chan_evt[g]),
            .evt_type_o (chan_type[g])
        );
    end

    assign load_out = !evt_valid_q || evt_ready;

    // Scan starts one past the last grant so every channel gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan_idx = CH_W'((int'(rr_q) + k) % NCH);
            if (!grant_vld && slot_vld_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_ch  = scan_idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            drain[i] = load_out && grant_vld && (grant_ch == CH_W'(i));
        end
    end

    // A slot emptied this clock may take a new event without overrun.
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_type_d = slot_type_q;
        ovf_d       = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            if (drain[i]) begin
                slot_vld_d[i] = 1'b0;
            end
            if (chan_evt[i]) begin
                if (slot_vld_q[i] && !drain[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    slot_vld_d[i]  = 1'b1;
                    slot_type_d[i] = chan_type[i];
                end
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_type_d  = evt_type_q;
        rr_d        = rr_q;
        if (load_out) begin
            evt_valid_d = grant_vld;
            if (grant_vld) begin
                evt_ch_d   = grant_ch;
                evt_type_d = slot_type_q[grant_ch];
                rr_d       = grant_ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q       <= '0;
            slot_vld_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_type_q[i] <= EVT_RELEASE;
            end
            rr_q        <= CH_W'(NCH - 1);
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_type_q  <= EVT_RELEASE;
            ovf_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            slot_vld_q  <= slot_vld_d;
            slot_type_q <= slot_type_d;
            rr_q        <= rr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_type_q  <= evt_type_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_type  = evt_type_q;
    assign evt_ovf   = ovf_q;

endmodule

`default_nettype wire
